// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
    localparam int PC_BITS = 64;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH, DROP} fetch_state_t;

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic [31:0]        instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_controller_queue.sv
// fetch_queue: synchronous FIFO of fetched {pc, instr} entries; flush beats push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic           do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so a full queue can still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC, drives the imem req/ready handshake and
// feeds IF/ID from a small queue, discarding fetches killed by EX redirects.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              QDEPTH   = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_adr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next, drop_adr;
    logic [CW-1:0]   count;
    logic            full, empty, xfer, push, pop;
    fetch_entry_t    head;

    // Gating with reset drops a request the moment reset is asserted.
    assign imem_req = reset && (state == DROP || count < CW'(QDEPTH));
    assign imem_adr = state == DROP ? drop_adr : pc;
    assign xfer     = imem_req && imem_ready;
    assign push     = xfer && state == FETCH && !redirect_valid;
    assign pop      = if_valid && !stall;

    always_comb begin
        state_next = state == DROP ? (xfer ? FETCH : DROP)
                   : (redirect_valid && imem_req && !imem_ready ? DROP : FETCH);
        pc_next    = redirect_valid ? redirect_pc & ~XLEN'(INSTR_BYTES - 1)
                   : push ? pc + XLEN'(INSTR_BYTES) : pc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            drop_adr <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            // Tracks pc while fetching, so entering DROP freezes the killed address.
            if (state == FETCH) drop_adr <= pc;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{pc: PC_BITS'(pc), instr: imem_instr}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign if_valid = !empty;
    assign if_instr = if_valid ? head.instr : '0;
    assign if_pc    = if_valid ? XLEN'(head.pc) : '0;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed plus randomized checks of fetch_controller
// against an instruction-stream scoreboard.
module tb_fetch_controller;
    logic        clk = 0, reset = 0, stall = 0, redirect_valid = 0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req, imem_ready, if_valid;
    logic [63:0] imem_adr, if_pc;
    logic [31:0] imem_instr, if_instr;

    int   checks = 0, failures = 0, deliv = 0, total = 0;
    int   lat = 0, wait_cnt = 0;
    logic rand_mode = 0, rnd_rdy = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_next;

    fetch_controller #(.XLEN(64), .QDEPTH(2), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_adr       (imem_adr),
        .imem_ready     (imem_ready),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h00C1_2103;
            64'h4:   return 32'h0021_00B3;
            64'h8:   return 32'h0010_2623;
            default: return (a[31:0] * 32'h9E37_79B1) ^ 32'h13;
        endcase
    endfunction

    // Instruction memory: ready after `lat` wait cycles, or per-cycle random.
    assign imem_instr = mem_word(imem_adr);
    assign imem_ready = imem_req && (rand_mode ? rnd_rdy : (wait_cnt >= lat));
    always @(posedge clk) wait_cnt <= (!imem_req || imem_ready) ? 0 : wait_cnt + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next += 64'd4;
        end
    endtask

    // The architectural stream restarts at the new target; anything older is void.
    task automatic restart(input logic [63:0] start);
        exp_q.delete();
        exp_next = start;
        deliv = 0;
        top_up();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 0;
        redirect_valid = 0;
        step();
        step();
        reset = 1;
        restart(64'h0);
    endtask

    // Monitor: handshake stability and in-order delivery of the expected stream.
    initial begin
        logic        prev_pend = 0;
        logic [63:0] prev_adr = '0, e;
        forever begin
            @(negedge clk);
            if (reset && prev_pend) begin
                check("hold_req", imem_req, 1);
                check("hold_adr", imem_adr, prev_adr);
            end
            prev_pend = reset && imem_req && !imem_ready;
            prev_adr  = imem_adr;
            if (reset && if_valid && !stall && !redirect_valid) begin
                top_up();
                e = exp_q.pop_front();
                check("deliver_pc", if_pc, e);
                check("deliver_instr", {32'h0, if_instr}, {32'h0, mem_word(e)});
                deliv++;
                total++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t_adr [13] = '{0, 0, 0, 4, 4, 4, 8, 8, 8, 'h40, 'h40, 'h40, 'h44};
        logic        t_v   [13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        logic [63:0] t_pc  [13] = '{0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 'h40};
        logic [31:0] t1_w  [3]  = '{32'h00C1_2103, 32'h0021_00B3, 32'h0010_2623};
        logic [63:0] rp;
        int          base;

        // Reset values
        step();
        step();
        check("rst_req", imem_req, 0);
        check("rst_adr", imem_adr, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pc", if_pc, 0);
        check("rst_instr", if_instr, 0);

        // Zero-wait stream: first valid one cycle after release
        reset = 1;
        restart(64'h0);
        #1;
        check("t1_req", imem_req, 1);
        check("t1_adr", imem_adr, 0);
        check("t1_first_valid", if_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_valid", if_valid, 1);
            check("t1_pc", if_pc, 64'(4 * i));
            check("t1_instr", if_instr, t1_w[i]);
        end

        // Stall fills the queue and parks the request
        do_reset();
        step();
        stall = 1;
        step();
        check("t2_req", imem_req, 0);
        check("t2_adr", imem_adr, 8);
        check("t2_head", if_pc, 0);
        repeat (3) step();
        stall = 0;
        for (int i = 0; i < 20 && deliv < 3; i++) step();
        check("t2_deliv", deliv, 3);

        // 3-cycle memory, then redirect to 0x40 while 0x8 is pending
        lat = 2;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            redirect_valid = (c == 7);
            redirect_pc = 64'h40;
            if (c == 7) restart(64'h40);
            #1;
            check("t3_req", imem_req, 1);
            check("t3_adr", imem_adr, t_adr[c]);
            check("t3_valid", if_valid, t_v[c]);
            if (t_v[c]) check("t3_pc", if_pc, t_pc[c]);
            step();
        end

        // Redirect with same-cycle transfer under stall, unaligned target
        lat = 0;
        stall = 1;
        do_reset();
        step();
        redirect_valid = 1;
        redirect_pc = 64'h103;
        restart(64'h100);
        #1;
        check("t5_req", imem_req, 1);
        step();
        redirect_valid = 0;
        #1;
        check("t5_flushed", if_valid, 0);
        check("t5_adr", imem_adr, 64'h100);
        stall = 0;
        step();
        check("t5_valid", if_valid, 1);
        check("t5_pc", if_pc, 64'h100);

        // PC wrap, then reset during a pending request
        redirect_valid = 1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        restart(64'hFFFF_FFFF_FFFF_FFFC);
        step();
        redirect_valid = 0;
        #1;
        check("t6_top_adr", imem_adr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("t6_wrap_adr", imem_adr, 0);
        check("t6_head", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        lat = 2;
        step();
        reset = 0;
        #1;
        check("t6_req_dropped", imem_req, 0);
        step();
        check("t6_rst_req", imem_req, 0);
        check("t6_rst_adr", imem_adr, 0);
        check("t6_rst_valid", if_valid, 0);
        check("t6_rst_pc", if_pc, 0);
        check("t6_rst_instr", if_instr, 0);

        // Randomized traffic against the stream scoreboard
        lat = 0;
        rand_mode = 1;
        do_reset();
        base = total;
        for (int c = 0; c < 800; c++) begin
            stall = $urandom_range(0, 3) == 0;
            rnd_rdy = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            rp = {$urandom, $urandom};
            redirect_pc = rp;
            if (redirect_valid) restart(rp & ~64'h3);
            step();
        end
        redirect_valid = 0;
        stall = 0;
        check("rand_progress", (total - base) > 150, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
